lamp_sqrt_ctrl: RTL

Initiator/wrapper side of the significand square-root core interface (doSqrt/s/is_exp_odd/special_case -> valid/res). Accepts a packed 16-bit lampFP operand over a valid/ready handshake and classifies special values. Drives the core with the normalized significand and exponent parity, then packs the core's 8-bit significand result with the halved exponent into a 16-bit lampFP result. It sits between the FPU issue stage and the sqrt core, with at most one operation outstanding.

---
 rtl/lampFPU_pkg.sv | 23 ++
 rtl/lamp_sqrt_ctrl_if.sv | 37 +++
 rtl/lamp_sqrt_classify.sv | 38 +++
 rtl/lamp_sqrt_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared lampFP types and constants for the square-root wrapper.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_BIAS = 127;

    localparam logic [15:0] LAMP_QNAN = 16'h7FC0;
    localparam logic [15:0] LAMP_PINF = 16'h7F80;

    typedef struct packed {
        logic                       sign;
        logic [LAMP_FLOAT_E_DW-1:0] exp;
        logic [LAMP_FLOAT_F_DW-1:0] frac;
    } lamp_float_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sqrt_ctrl_state_t;

endpackage

// File: rtl/lamp_sqrt_ctrl_if.sv
// Issue-side handshake plus sqrt-core interface; slave = controller, master = its environment.
// Optional flag outputs exist only when LAMP_SQRT_FLAGS_EN is defined.
interface lamp_sqrt_ctrl_if;
    logic        valid_i;
    logic [15:0] op_i;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] res_o;
    logic        core_do_sqrt_o;
    logic [7:0]  core_s_o;
    logic        core_is_exp_odd_o;
    logic        core_special_case_o;
    logic        core_valid_i;
    logic [7:0]  core_res_i;
`ifdef LAMP_SQRT_FLAGS_EN
    logic        invalid_o;
    logic        inexact_o;
`endif

    modport slave (
        input  valid_i, op_i, core_valid_i, core_res_i,
        output ready_o, valid_o, res_o, core_do_sqrt_o, core_s_o,
               core_is_exp_odd_o, core_special_case_o
`ifdef LAMP_SQRT_FLAGS_EN
        , output invalid_o, inexact_o
`endif
    );

    modport master (
        output valid_i, op_i, core_valid_i, core_res_i,
        input  ready_o, valid_o, res_o, core_do_sqrt_o, core_s_o,
               core_is_exp_odd_o, core_special_case_o
`ifdef LAMP_SQRT_FLAGS_EN
        , input invalid_o, inexact_o
`endif
    );
endinterface

// File: rtl/lamp_sqrt_classify.sv
// Purpose: classify a lampFP operand for sqrt and pick the special-value result.
// Latency: combinational.
// Backpressure: none.
module lamp_sqrt_classify
    import lampFPU_pkg::*;
(
    input  lamp_float_t op,
    output logic        is_nan,
    output logic        is_neg,
    output logic        is_inf,
    output logic        is_zero,
    output logic [15:0] special_res
);
    logic exp_max;
    logic exp_min;
    logic frac_nz;

    assign exp_max = (op.exp == '1);
    assign exp_min = (op.exp == '0);
    assign frac_nz = (op.frac != '0);

    // Flags are mutually exclusive; is_zero also covers positive denormals (flushed).
    assign is_nan  = exp_max & frac_nz;
    assign is_neg  = ~is_nan & op.sign & ~(exp_min & ~frac_nz);
    assign is_inf  = exp_max & ~frac_nz & ~op.sign;
    assign is_zero = exp_min & ~is_neg;

    always_comb begin
        special_res = 16'h0000;
        if (is_nan || is_neg) begin
            special_res = LAMP_QNAN;
        end else if (is_inf) begin
            special_res = LAMP_PINF;
        end else if (is_zero) begin
            special_res = {op.sign, 15'h0000};
        end
    end
endmodule

// File: rtl/lamp_sqrt_ctrl.sv
// Purpose: lampFP sqrt wrapper - classify, drive significand core, pack result (opt. LAMP_SQRT_FLAGS_EN).
// Latency: specials accept->valid_o in 3 cycles; normals valid_o one cycle after core_valid_i.
// Backpressure: ready_o high only in IDLE; one operation outstanding, re-accept on the valid_o cycle.
module lamp_sqrt_ctrl
    import lampFPU_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    lamp_sqrt_ctrl_if.slave bus
);
    sqrt_ctrl_state_t state;
    lamp_float_t      op_in;

    logic        is_nan, is_neg, is_inf, is_zero, is_special;
    logic [15:0] special_res;

    logic [LAMP_FLOAT_E_DW-1:0] exp_q;
    logic        special_q;
    logic [15:0] special_res_q;

    logic        valid_q;
    logic [15:0] res_q;
    logic        do_sqrt_q;
    logic [7:0]  s_q;
    logic        exp_odd_q;
    logic        special_case_q;

    logic [8:0]  exp_sum;
    logic [7:0]  res_exp;
    logic [15:0] normal_res;

    assign op_in = bus.op_i;

    lamp_sqrt_classify u_classify (
        .op          (op_in),
        .is_nan      (is_nan),
        .is_neg      (is_neg),
        .is_inf      (is_inf),
        .is_zero     (is_zero),
        .special_res (special_res)
    );

    assign is_special = is_nan | is_neg | is_inf | is_zero;

    // Halved exponent: floor((e-127)/2)+127 == (e+127)>>1, range 64..190.
    assign exp_sum = {1'b0, exp_q} + 9'(LAMP_FLOAT_BIAS);
    assign res_exp = exp_sum[8:1];

    // A zero core result means the significand rounded up to 2.0.
    always_comb begin
        normal_res = {1'b0, res_exp, bus.core_res_i[6:0]};
        if (bus.core_res_i == 8'h00) begin
            normal_res = {1'b0, res_exp + 8'd1, 7'h00};
        end
    end

`ifdef LAMP_SQRT_FLAGS_EN
    logic        invalid_in_q;
    logic        invalid_q;
    logic        inexact_q;
    logic [15:0] res_sq;
    logic [15:0] s_ref;

    assign res_sq = 16'(bus.core_res_i) * 16'(bus.core_res_i);
    assign s_ref  = exp_odd_q ? {s_q, 8'h00} : {1'b0, s_q, 7'h00};

    assign bus.invalid_o = invalid_q;
    assign bus.inexact_o = inexact_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            exp_q          <= '0;
            special_q      <= 1'b0;
            special_res_q  <= '0;
            valid_q        <= 1'b0;
            res_q          <= '0;
            do_sqrt_q      <= 1'b0;
            s_q            <= '0;
            exp_odd_q      <= 1'b0;
            special_case_q <= 1'b0;
`ifdef LAMP_SQRT_FLAGS_EN
            invalid_in_q   <= 1'b0;
            invalid_q      <= 1'b0;
            inexact_q      <= 1'b0;
`endif
        end else begin
            valid_q        <= 1'b0;
            do_sqrt_q      <= 1'b0;
            special_case_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        exp_q          <= op_in.exp;
                        special_q      <= is_special;
                        special_res_q  <= special_res;
                        s_q            <= {1'b1, op_in.frac};
                        exp_odd_q      <= ~op_in.exp[0];
                        do_sqrt_q      <= ~is_special;
                        special_case_q <= is_special;
`ifdef LAMP_SQRT_FLAGS_EN
                        invalid_in_q   <= is_nan | is_neg;
`endif
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.core_valid_i) begin
                        valid_q <= 1'b1;
                        res_q   <= special_q ? special_res_q : normal_res;
`ifdef LAMP_SQRT_FLAGS_EN
                        invalid_q <= invalid_in_q;
                        inexact_q <= ~special_q & (res_sq != s_ref);
`endif
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o             = (state == IDLE);
    assign bus.valid_o             = valid_q;
    assign bus.res_o               = res_q;
    assign bus.core_do_sqrt_o      = do_sqrt_q;
    assign bus.core_s_o            = s_q;
    assign bus.core_is_exp_odd_o   = exp_odd_q;
    assign bus.core_special_case_o = special_case_q;
endmodule
